// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the serial adder; master issues operands, slave returns the sum.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// Single-bit full adder, purely combinational: f = a^b^c, g = majority(a,b,c).
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f,
  output logic g
);

  assign f = a ^ b ^ c;
  assign g = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: done appears WIDTH edges after an accepted start, one add per WIDTH+2 cycles.
// start is only honoured in IDLE; requests while busy are dropped, not queued.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;

  full_adder_bit u_fa (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .c (carry),
    .f (fa_s),
    .g (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          // Publish the word only on the last bit so sum/cout never show partial results.
          if (cnt == LAST_BIT) begin
            sum_q  <= {fa_s, sum_sr[WIDTH-1:1]};
            cout_q <= fa_c;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and back-to-back checks of serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_sum;
  logic       exp_cout;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input bit glitch, input string tag);
    logic [8:0] r;
    int lat;
    int busy_cnt;
    int extra_done;
    r = {1'b0, av} + {1'b0, bv} + {8'b0, ci};
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = ci;
    @(negedge clk);
    bus.start = 1'b0; bus.a = ~av; bus.b = ~bv; bus.cin = ~ci;
    lat = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      busy_cnt += (bus.busy === 1'b1) ? 1 : 0;
      check({tag, "_hold"}, {bus.cout, bus.sum}, {exp_cout, exp_sum});
      if (glitch && lat == 3) begin
        bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'hF0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    busy_cnt += (bus.busy === 1'b1) ? 1 : 0;
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 9);
    check({tag, "_result"}, {bus.cout, bus.sum}, {23'b0, r});
    exp_sum = r[7:0];
    exp_cout = r[8];
    if (glitch) begin
      bus.start = 1'b1; bus.a = 8'hF0; bus.b = 8'hF0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_idle_flags"}, {bus.busy, bus.done}, 0);
    check({tag, "_held"}, {bus.cout, bus.sum}, {23'b0, r});
    if (glitch) begin
      extra_done = 0;
      repeat (12) begin
        @(negedge clk);
        extra_done += (bus.done === 1'b1 || bus.busy === 1'b1) ? 1 : 0;
      end
      check({tag, "_no_requeue"}, extra_done, 0);
    end
  endtask

  logic [7:0] qa [100];
  logic [7:0] qb [100];
  logic       qc [100];

  initial begin
    logic [8:0] r;
    int lat;
    int dones;
    checks = 0;
    errors = 0;
    exp_sum = 8'h00;
    exp_cout = 1'b0;
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum_cout", {bus.cout, bus.sum}, 0);
    rst_n = 1'b1;

    do_add(8'h00, 8'h00, 1'b0, 1'b0, "t1_zero");
    do_add(8'hFF, 8'h01, 1'b0, 1'b0, "t2_wrap");
    do_add(8'h5A, 8'h3C, 1'b1, 1'b0, "t3_mixed");
    do_add(8'hFF, 8'hFF, 1'b1, 1'b0, "t3_max");
    do_add(8'h11, 8'h22, 1'b0, 1'b1, "t4_ignored_start");

    // Reset in the middle of an addition
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_done", bus.done, 0);
    check("t5_rst_sum_cout", {bus.cout, bus.sum}, 0);
    exp_sum = 8'h00;
    exp_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      dones += (bus.done === 1'b1) ? 1 : 0;
    end
    check("t5_no_done_after_rst", dones, 0);
    do_add(8'h80, 8'h7F, 1'b1, 1'b0, "t5_after_rst");

    // Back-to-back with start held high
    for (int i = 0; i < 100; i++) begin
      qa[i] = 8'($urandom);
      qb[i] = 8'($urandom);
      qc[i] = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.a = qa[0]; bus.b = qb[0]; bus.cin = qc[0];
    for (int i = 0; i < 100; i++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (bus.done !== 1'b1 && lat < 40);
      r = {1'b0, qa[i]} + {1'b0, qb[i]} + {8'b0, qc[i]};
      check("t6_interval", lat, (i == 0) ? 9 : 10);
      check("t6_result", {bus.cout, bus.sum}, {23'b0, r});
      if (i < 99) begin
        bus.a = qa[i+1]; bus.b = qb[i+1]; bus.cin = qc[i+1];
      end
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_end_idle", {bus.busy, bus.done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
